pipeline_hazard_unit: RTL

Central hazard controller for the 5-stage 64-bit RISC-V pipeline, placed beside the IF_ID/ID_EX/EX_MEM/MEM_WB register banks. It tracks a shadow copy of each instruction's register fields and control bits through EX, MEM and WB. From these it drives the per-stage register enables, the bubble/flush controls and the two 3-input operand-forwarding mux selects. It generalises the free-running pipeline with three additions:
- parametrised register-address width;
- load-use stalls and branch/jump flushes;
- a parametrised multi-cycle data-memory latency that freezes the whole pipeline.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/fwd_select.sv | 36 +++
 rtl/reg_arstn_en.sv | 27 ++
 rtl/pipeline_hazard_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg
//   Shared definitions for the pipeline hazard controller: forwarding-mux
//   select codes, the control-bit bundle carried by the shadow stages, the
//   bubble value of that bundle, and the per-cycle hazard action.
package cpu_pkg;

   // EX operand forwarding select
   localparam logic [1:0] FWD_REG = 2'b00;   // register file read data
   localparam logic [1:0] FWD_WB  = 2'b01;   // WB-stage result
   localparam logic [1:0] FWD_MEM = 2'b10;   // EX_MEM alu_out

   // Decoded control bits tracked alongside each instruction
   typedef struct packed {
      logic reg_write;
      logic mem_read;
      logic mem_write;
   } ctl_t;

   // A bubble carries no register write and no memory access
   localparam ctl_t CTL_BUBBLE = '0;

   // Outcome of the per-cycle hazard decision
   typedef enum logic [2:0] {
      ACT_HOLD,       // global enable low
      ACT_FREEZE,     // data memory still busy
      ACT_REDIRECT,   // taken branch / jump in EX
      ACT_LOAD_USE,   // consumer in IF_ID needs the load in EX
      ACT_RUN         // free-running advance
   } hz_action_e;

endpackage

// File: rtl/fwd_select.sv
// fwd_select
//   Chooses the source of one EX operand from the MEM and WB shadow fields.
//   MEM wins over WB; loads in MEM are not forwarded (their data is not ready
//   yet) and register index 0 is never forwarded.
//   Ports:
//     ex_rs          in   source index of the operand in EX
//     mem_rd         in   destination index in MEM
//     mem_reg_write  in   MEM instruction writes a register
//     mem_mem_read   in   MEM instruction is a load
//     wb_rd          in   destination index in WB
//     wb_reg_write   in   WB instruction writes a register
//     sel            out  [1:0] FWD_REG / FWD_WB / FWD_MEM
module fwd_select
   import cpu_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = 5
) (
   input  logic [REG_ADDR_W-1:0] ex_rs,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic                  mem_reg_write,
   input  logic                  mem_mem_read,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   input  logic                  wb_reg_write,
   output logic [1:0]            sel
);

   always_comb begin
      sel = FWD_REG;
      if (mem_reg_write && !mem_mem_read && (mem_rd != '0) && (mem_rd == ex_rs)) begin
         sel = FWD_MEM;
      end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs)) begin
         sel = FWD_WB;
      end
   end

endmodule

// File: rtl/reg_arstn_en.sv
// reg_arstn_en
//   Generic W-bit register with asynchronous active-low clear and load enable.
//   Ports:
//     clk     in   clock
//     arst_n  in   asynchronous active-low reset (clears q)
//     en      in   load enable
//     d       in   [W-1:0] next value
//     q       out  [W-1:0] registered value
module reg_arstn_en #(
   parameter int unsigned W = 1
) (
   input  logic         clk,
   input  logic         arst_n,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit
//   Central hazard controller for the 5-stage pipeline. Keeps shadow copies of
//   the register fields and control bits of the instructions in EX, MEM and
//   WB, and from them drives stage enables, bubble/flush controls, operand
//   forwarding selects and the data-memory wait.
//   Parameters:
//     REG_ADDR_W  register-index width
//     MEM_LAT     data-memory access cycles (>=1); 1 means no memory stall
//   Ports:
//     clk, arst_n                     clock, async active-low reset
//     enable                          global run enable
//     id_rs1, id_rs2, id_rd           register fields of the instruction in IF_ID
//     id_reg_write, id_mem_read,
//     id_mem_write                    decoded control of the instruction in IF_ID
//     ex_redirect                     taken branch / jump resolved in EX
//     pc_en, if_id_en, id_ex_en,
//     ex_mem_en, mem_wb_en            PC and stage register enables
//     if_id_flush, id_ex_flush        load a bubble into IF_ID / ID_EX
//     fwd_a, fwd_b                    EX operand forwarding selects
//     mem_busy                        data-memory wait in progress
//   All outputs are combinational from shadow state and current inputs.
module pipeline_hazard_unit
   import cpu_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned MEM_LAT    = 1
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic                  enable,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_reg_write,
   input  logic                  id_mem_read,
   input  logic                  id_mem_write,
   input  logic                  ex_redirect,
   output logic                  pc_en,
   output logic                  if_id_en,
   output logic                  id_ex_en,
   output logic                  ex_mem_en,
   output logic                  mem_wb_en,
   output logic                  if_id_flush,
   output logic                  id_ex_flush,
   output logic [1:0]            fwd_a,
   output logic [1:0]            fwd_b,
   output logic                  mem_busy
);

   localparam int unsigned RW = REG_ADDR_W;

   typedef struct packed {
      logic [RW-1:0] rs1;
      logic [RW-1:0] rs2;
      logic [RW-1:0] rd;
      ctl_t          ctl;
   } ex_sh_t;

   typedef struct packed {
      logic [RW-1:0] rd;
      ctl_t          ctl;
   } mem_sh_t;

   typedef struct packed {
      logic [RW-1:0] rd;
      logic          reg_write;
   } wb_sh_t;

   ex_sh_t  ex_d,  ex_q;
   mem_sh_t mem_d, mem_q;
   wb_sh_t  wb_d,  wb_q;

   logic       load_use;
   logic       mem_op;
   hz_action_e action;

   // ------------------------------------------------------------------
   // Shadow stages; all three advance together with EX_MEM
   // ------------------------------------------------------------------
   always_comb begin
      if (id_ex_flush) begin
         ex_d = '{rs1: '0, rs2: '0, rd: '0, ctl: CTL_BUBBLE};
      end else begin
         ex_d = '{rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                  ctl: '{reg_write: id_reg_write, mem_read: id_mem_read,
                         mem_write: id_mem_write}};
      end
   end

   assign mem_d = '{rd: ex_q.rd, ctl: ex_q.ctl};
   assign wb_d  = '{rd: mem_q.rd, reg_write: mem_q.ctl.reg_write};

   reg_arstn_en #(.W($bits(ex_sh_t))) u_ex_shadow (
      .clk    (clk),
      .arst_n (arst_n),
      .en     (ex_mem_en),
      .d      (ex_d),
      .q      (ex_q)
   );

   reg_arstn_en #(.W($bits(mem_sh_t))) u_mem_shadow (
      .clk    (clk),
      .arst_n (arst_n),
      .en     (ex_mem_en),
      .d      (mem_d),
      .q      (mem_q)
   );

   reg_arstn_en #(.W($bits(wb_sh_t))) u_wb_shadow (
      .clk    (clk),
      .arst_n (arst_n),
      .en     (ex_mem_en),
      .d      (wb_d),
      .q      (wb_q)
   );

   // ------------------------------------------------------------------
   // Operand forwarding
   // ------------------------------------------------------------------
   fwd_select #(.REG_ADDR_W(RW)) u_fwd_a (
      .ex_rs         (ex_q.rs1),
      .mem_rd        (mem_q.rd),
      .mem_reg_write (mem_q.ctl.reg_write),
      .mem_mem_read  (mem_q.ctl.mem_read),
      .wb_rd         (wb_q.rd),
      .wb_reg_write  (wb_q.reg_write),
      .sel           (fwd_a)
   );

   fwd_select #(.REG_ADDR_W(RW)) u_fwd_b (
      .ex_rs         (ex_q.rs2),
      .mem_rd        (mem_q.rd),
      .mem_reg_write (mem_q.ctl.reg_write),
      .mem_mem_read  (mem_q.ctl.mem_read),
      .wb_rd         (wb_q.rd),
      .wb_reg_write  (wb_q.reg_write),
      .sel           (fwd_b)
   );

   // ------------------------------------------------------------------
   // Data-memory wait
   // ------------------------------------------------------------------
   assign mem_op = mem_q.ctl.mem_read | mem_q.ctl.mem_write;

   generate
      if (MEM_LAT > 1) begin : g_wait
         localparam int unsigned CNT_W = $clog2(MEM_LAT) + 1;

         logic [CNT_W-1:0] cnt_q;
         logic [CNT_W-1:0] cnt_eff;
         logic             waited_q;

         // On its first cycle in MEM an operation has not been counted yet;
         // the counter value it would hold then is MEM_LAT-1 remaining freeze
         // cycles, so it is substituted combinationally and the register
         // only ever holds the already-decremented remainder.
         assign cnt_eff  = waited_q ? cnt_q : CNT_W'(MEM_LAT - 1);
         assign mem_busy = waited_q ? (cnt_q != '0) : mem_op;

         always_ff @(posedge clk or negedge arst_n) begin
            if (!arst_n) begin
               cnt_q    <= '0;
               waited_q <= 1'b0;
            end else if (enable) begin
               if (mem_busy) begin
                  cnt_q    <= cnt_eff - CNT_W'(1);
                  waited_q <= 1'b1;
               end else begin
                  // not busy with enable high means the stages advance,
                  // so the next MEM occupant starts its own wait
                  waited_q <= 1'b0;
               end
            end
         end
      end else begin : g_no_wait
         logic mem_op_unused;
         assign mem_op_unused = mem_op;
         assign mem_busy      = 1'b0;
      end
   endgenerate

   // ------------------------------------------------------------------
   // Hazard decision
   // ------------------------------------------------------------------
   assign load_use = ex_q.ctl.mem_read && (ex_q.rd != '0) &&
                     ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2));

   always_comb begin
      if (!enable) begin
         action = ACT_HOLD;
      end else if (mem_busy) begin
         action = ACT_FREEZE;
      end else if (ex_redirect) begin
         action = ACT_REDIRECT;
      end else if (load_use) begin
         action = ACT_LOAD_USE;
      end else begin
         action = ACT_RUN;
      end
   end

   always_comb begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      ex_mem_en   = 1'b0;
      mem_wb_en   = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      case (action)
         ACT_REDIRECT: begin
            pc_en       = 1'b1;
            if_id_en    = 1'b1;
            id_ex_en    = 1'b1;
            ex_mem_en   = 1'b1;
            mem_wb_en   = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
         end
         ACT_LOAD_USE: begin
            // hold PC and IF_ID, inject a bubble into EX, let the load move on
            id_ex_en    = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_en   = 1'b1;
            mem_wb_en   = 1'b1;
         end
         ACT_RUN: begin
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            mem_wb_en = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule
